axi_dma_rd_arbiter: RTL and testbench
=====================================

AXI_DMA_RD_ARBITER -- requirements
Module: axi_dma_rd_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, byte address width on requester and AXI side.
REQ-002 Parameter DATA_WIDTH, default 32, read data width; one beat is DATA_WIDTH/8 bytes.
REQ-003 clk  in  1  single clock for all logic; also the s_axi_dma_aclk domain.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 req_valid[n], n=0..1  in  1 each  requester n has a burst request pending.
REQ-006 req_ready[n]  out  1 each  request n accepted this cycle.
REQ-007 req_addr[n]  in  ADDR_WIDTH each  burst start address, beat-aligned.
REQ-008 req_len[n]  in  8 each  beats minus one (0..255).
REQ-009 rd_data  out  DATA_WIDTH  returned beat, shared by both requesters.
REQ-010 rd_valid[n]  out  1 each  beat on rd_data belongs to requester n.
REQ-011 rd_last  out  1  final beat of current burst.
REQ-012 rd_ready[n]  in  1 each  requester n accepts beat.
REQ-013 m_araddr, m_arlen, m_arsize(3), m_arcache(4), m_arprot(3), m_arvalid  out  AXI4 AR channel to s_axi_dma.
REQ-014 m_arready  in  1  AR accept.
REQ-015 m_rdata (DATA_WIDTH), m_rlast, m_rvalid  in  AXI4 R channel.
REQ-016 m_rready  out  1  R accept.
REQ-017 busy  out  1  burst in progress; err_4k  out  1  single-cycle illegal-request pulse.

Function
REQ-018 FSM states IDLE, ADDR, DATA; exactly one burst outstanding at any time.
REQ-019 IDLE: if any req_valid, grant per round-robin, assert req_ready[grant] for exactly one cycle, latch addr/len/grant, go ADDR next cycle.
REQ-020 Round-robin: priority pointer starts at requester 0; after each grant it points to the other requester; a lone valid requester is always granted.
REQ-021 Simultaneous req_valid[0] and req_valid[1]: pointer holder is granted; the other is granted next IDLE.
REQ-022 ADDR: m_arvalid=1 with latched m_araddr, m_arlen; m_arsize=log2(DATA_WIDTH/8), m_arcache=4'b0011, m_arprot=3'b000 constant; on m_arvalid&&m_arready go DATA.
REQ-023 AR signals held stable while m_arvalid=1 and m_arready=0.
REQ-024 DATA: rd_data=m_rdata, rd_last=m_rlast, rd_valid[grant]=m_rvalid, m_rready=rd_ready[grant]; combinational pass-through, zero added latency.
REQ-025 rd_valid of non-granted requester is 0 at all times.
REQ-026 Beat counter counts accepted beats; transfer completes on the beat where count==len; go IDLE next cycle.
REQ-027 m_rlast arriving before count==len, or count==len without m_rlast: burst still ends on count==len; m_rlast is forwarded unmodified.
REQ-028 Request whose burst crosses a 4 KB boundary (addr[11:0] + (len+1)*bytes > 4096): not granted-to-AXI; req_ready pulses, err_4k pulses one cycle, FSM stays IDLE, pointer advances.
REQ-029 busy=1 in ADDR and DATA, 0 in IDLE.
REQ-030 Minimum IDLE occupancy between bursts is one cycle.

Reset
REQ-031 Assertion of reset forces state IDLE, pointer to 0, beat counter 0, immediately and asynchronously.
REQ-032 Reset values: req_ready=0, rd_valid=0, rd_last=0, m_arvalid=0, m_rready=0, busy=0, err_4k=0, m_araddr=0, m_arlen=0.
REQ-033 Reset mid-burst abandons the burst; no beat is forwarded after reset deasserts until a new grant.

Structure
REQ-034 Shared package axi_dma_pkg holds state enum, AXI cache/prot constants and 4 KB boundary constant.
REQ-035 Round-robin grant logic in sub-module rr_arbiter_2 (inputs req[1:0], advance; outputs grant, grant_valid).

Verification
REQ-036 Single req0 addr=0x1000, len=3, m_arready at once, 4 beats -> req_ready[0] one cycle, AR 0x1000/arlen 3, rd_valid[0] 4 beats, busy low after.
REQ-037 req0 and req1 asserted together from reset, each len=0 -> req0 served first, then req1; third simultaneous request -> req0 again.
REQ-038 m_arready held low 5 cycles -> m_araddr/m_arlen stable and m_arvalid high for all 5 cycles.
REQ-039 rd_ready[1] toggled 1/0 during 8-beat burst -> m_rready mirrors it; all 8 beats delivered in order; rd_valid[0]=0 throughout.
REQ-040 req addr=0x0FF8, len=3, DATA_WIDTH 32 -> err_4k one pulse, no m_arvalid, FSM IDLE.
REQ-041 reset asserted on beat 2 of 4 -> m_rready, rd_valid, busy 0 same cycle; next request starts a clean AR.

Source files
------------

// File: rtl/axi_dma_pkg.sv
// Shared types and constants for the DMA read arbiter: FSM state encoding,
// fixed AXI AR attributes and the 4 KB burst boundary check.
package axi_dma_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2
   } state_t;

   localparam logic [3:0]  AR_CACHE    = 4'b0011;
   localparam logic [2:0]  AR_PROT     = 3'b000;
   localparam int unsigned BOUNDARY_4K = 4096;

   // True when a burst starting at this page offset runs past the 4 KB page.
   function automatic logic crosses_4k(input logic [11:0]  offset,
                                       input logic [7:0]   len,
                                       input int unsigned  beat_bytes);
      int unsigned span;
      span = 32'(offset) + (32'(len) + 32'd1) * beat_bytes;
      return (span > BOUNDARY_4K);
   endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter. A lone requester always wins; on a tie the
// pointer holder wins. After a taken grant the pointer moves to the loser.
module rr_arbiter_2 (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic       advance,
   output logic       grant,
   output logic       grant_valid
);

   logic ptr;

   // Priority pointer, moves away from whoever was just granted.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         ptr <= 1'b0;
      else if (advance && grant_valid)
         ptr <= ~grant;
   end

   // Grant selection: tie goes to the pointer, otherwise the only requester.
   always_comb begin
      grant_valid = |req;
      if (req == 2'b11)
         grant = ptr;
      else
         grant = req[1];
   end

endmodule

// File: rtl/axi_dma_rd_arbiter.sv
// Arbitrates two DMA read requesters onto one AXI4 read master port with a
// single burst outstanding. R-channel beats are passed through combinationally
// to the granted requester.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   IDLE    | no burst; grant one request (or reject a 4 KB crossing)
//   ADDR    | AR presented with latched addr/len until m_arready
//   DATA    | beats forwarded to granted requester until count == len
module axi_dma_rd_arbiter
   import axi_dma_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [1:0]                 req_valid,
   output logic [1:0]                 req_ready,
   input  logic [1:0][ADDR_WIDTH-1:0] req_addr,
   input  logic [1:0][7:0]            req_len,
   output logic [DATA_WIDTH-1:0]      rd_data,
   output logic [1:0]                 rd_valid,
   output logic                       rd_last,
   input  logic [1:0]                 rd_ready,
   output logic [ADDR_WIDTH-1:0]      m_araddr,
   output logic [7:0]                 m_arlen,
   output logic [2:0]                 m_arsize,
   output logic [3:0]                 m_arcache,
   output logic [2:0]                 m_arprot,
   output logic                       m_arvalid,
   input  logic                       m_arready,
   input  logic [DATA_WIDTH-1:0]      m_rdata,
   input  logic                       m_rlast,
   input  logic                       m_rvalid,
   output logic                       m_rready,
   output logic                       busy,
   output logic                       err_4k
);

   localparam int unsigned BEAT_BYTES = DATA_WIDTH / 8;
   localparam logic [2:0]  AR_SIZE    = 3'($clog2(BEAT_BYTES));

   state_t                state, state_nxt;
   logic                  grant, grant_valid;
   logic                  advance, load, beat_take, req_bad;
   logic                  gnt_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [7:0]            len_q;
   logic [7:0]            beat_cnt;

   rr_arbiter_2 u_rr (
      .clk         (clk),
      .reset       (reset),
      .req         (req_valid),
      .advance     (advance),
      .grant       (grant),
      .grant_valid (grant_valid)
   );

   assign req_bad   = crosses_4k(req_addr[grant][11:0], req_len[grant], BEAT_BYTES);
   assign rd_data   = m_rdata;
   assign m_araddr  = addr_q;
   assign m_arlen   = len_q;
   assign m_arsize  = AR_SIZE;
   assign m_arcache = AR_CACHE;
   assign m_arprot  = AR_PROT;

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   // Next-state and output decode; reset also masks the grant handshake.
   always_comb begin
      state_nxt = state;
      req_ready = 2'b00;
      err_4k    = 1'b0;
      advance   = 1'b0;
      load      = 1'b0;
      m_arvalid = 1'b0;
      m_rready  = 1'b0;
      rd_valid  = 2'b00;
      rd_last   = 1'b0;
      busy      = 1'b0;
      beat_take = 1'b0;
      case (state)
         ST_IDLE: begin
            if (grant_valid && !reset) begin
               req_ready[grant] = 1'b1;
               advance          = 1'b1;
               if (req_bad) begin
                  err_4k = 1'b1;
               end else begin
                  load      = 1'b1;
                  state_nxt = ST_ADDR;
               end
            end
         end
         ST_ADDR: begin
            busy      = 1'b1;
            m_arvalid = 1'b1;
            if (m_arready)
               state_nxt = ST_DATA;
         end
         ST_DATA: begin
            busy            = 1'b1;
            m_rready        = rd_ready[gnt_q];
            rd_valid[gnt_q] = m_rvalid;
            rd_last         = m_rlast;
            beat_take       = m_rvalid && rd_ready[gnt_q];
            if (beat_take && (beat_cnt == len_q))
               state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Latch the granted request for the AR channel and beat routing.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         addr_q <= '0;
         len_q  <= '0;
         gnt_q  <= 1'b0;
      end else if (load) begin
         addr_q <= req_addr[grant];
         len_q  <= req_len[grant];
         gnt_q  <= grant;
      end
   end

   // Accepted-beat counter; burst length comes from len, not m_rlast.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         beat_cnt <= '0;
      else if (load)
         beat_cnt <= '0;
      else if (beat_take) begin
         if (beat_cnt == len_q)
            beat_cnt <= '0;
         else
            beat_cnt <= beat_cnt + 8'd1;
      end
   end

endmodule

// File: tb/tb_axi_dma_rd_arbiter.sv
// Bench for axi_dma_rd_arbiter: plays both requesters and the AXI slave,
// and checks every cycle against a transaction-level model.
module tb_axi_dma_rd_arbiter;

   localparam int AW    = 32;
   localparam int DW    = 32;
   localparam int BYTES = DW / 8;

   logic               clk = 1'b0;
   logic               reset;
   logic [1:0]         req_valid, req_ready;
   logic [1:0][AW-1:0] req_addr;
   logic [1:0][7:0]    req_len;
   logic [DW-1:0]      rd_data;
   logic [1:0]         rd_valid;
   logic               rd_last;
   logic [1:0]         rd_ready;
   logic [AW-1:0]      m_araddr;
   logic [7:0]         m_arlen;
   logic [2:0]         m_arsize;
   logic [3:0]         m_arcache;
   logic [2:0]         m_arprot;
   logic               m_arvalid, m_arready;
   logic [DW-1:0]      m_rdata;
   logic               m_rlast, m_rvalid, m_rready;
   logic               busy, err_4k;

   always #5 clk = ~clk;

   axi_dma_rd_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_addr  (req_addr),
      .req_len   (req_len),
      .rd_data   (rd_data),
      .rd_valid  (rd_valid),
      .rd_last   (rd_last),
      .rd_ready  (rd_ready),
      .m_araddr  (m_araddr),
      .m_arlen   (m_arlen),
      .m_arsize  (m_arsize),
      .m_arcache (m_arcache),
      .m_arprot  (m_arprot),
      .m_arvalid (m_arvalid),
      .m_arready (m_arready),
      .m_rdata   (m_rdata),
      .m_rlast   (m_rlast),
      .m_rvalid  (m_rvalid),
      .m_rready  (m_rready),
      .busy      (busy),
      .err_4k    (err_4k)
   );

   typedef struct packed {
      logic [31:0] addr;
      logic [7:0]  len;
   } req_t;

   int n_total = 0;
   int n_bad   = 0;

   // model state: pending requests, priority, outstanding burst
   req_t        rq[2][$];
   int          pref;
   bit          mbusy, ar_pending;
   int          cur_who;
   logic [31:0] cur_addr;
   logic [7:0]  cur_len;
   int          beats_got;
   int          grant_log[$];
   int          n_err, n_ar;
   int          n_beats[2];
   int          p_arready, p_rvalid, p_rdready;
   bit          rlast_rand;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         if (n_bad <= 40)
            $display("FAIL %s: got=%0h want=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_clear();
      pref       = 0;
      mbusy      = 1'b0;
      ar_pending = 1'b0;
      beats_got  = 0;
   endtask

   // One clock cycle: drive, check against the model, advance the model.
   task automatic step();
      logic [1:0]  vv, exp_ready, exp_rv;
      int          g;
      bit          crossing, in_data;
      logic [31:0] a;
      logic [7:0]  l;
      g = 0; crossing = 1'b0; a = '0; l = '0;
      for (int n = 0; n < 2; n++) begin
         if (rq[n].size() > 0) begin
            req_valid[n] = 1'b1;
            req_addr[n]  = rq[n][0].addr;
            req_len[n]   = rq[n][0].len;
         end else begin
            req_valid[n] = 1'b0;
            req_addr[n]  = $urandom;
            req_len[n]   = 8'($urandom);
         end
         rd_ready[n] = ($urandom_range(99) < p_rdready);
      end
      in_data   = mbusy && !ar_pending;
      m_arready = ($urandom_range(99) < p_arready);
      m_rvalid  = ($urandom_range(99) < p_rvalid);
      m_rdata   = $urandom;
      m_rlast   = rlast_rand ? 1'($urandom) : (in_data && beats_got == int'(cur_len));
      #1;
      vv        = req_valid;
      exp_ready = 2'b00;
      if (!mbusy && vv != 2'b00) begin
         g         = (vv == 2'b11) ? pref : (vv[1] ? 1 : 0);
         exp_ready = 2'b01 << g;
         a         = rq[g][0].addr;
         l         = rq[g][0].len;
         crossing  = (int'(a[11:0]) + (int'(l) + 1) * BYTES) > 4096;
      end
      check_val("req_ready", req_ready, exp_ready);
      check_val("err_4k", err_4k, crossing);
      check_val("busy", busy, mbusy);
      check_val("m_arvalid", m_arvalid, ar_pending);
      check_val("m_arsize", m_arsize, 3'd2);
      check_val("m_arcache", m_arcache, 4'b0011);
      check_val("m_arprot", m_arprot, 3'b000);
      if (ar_pending) begin
         check_val("m_araddr", m_araddr, cur_addr);
         check_val("m_arlen", m_arlen, cur_len);
      end
      if (in_data) begin
         exp_rv = m_rvalid ? (2'b01 << cur_who) : 2'b00;
         check_val("m_rready", m_rready, rd_ready[cur_who]);
         check_val("rd_valid", rd_valid, exp_rv);
         check_val("rd_last", rd_last, m_rlast);
         if (m_rvalid)
            check_val("rd_data", rd_data, m_rdata);
      end else begin
         check_val("m_rready_idle", m_rready, 1'b0);
         check_val("rd_valid_idle", rd_valid, 2'b00);
      end
      if (exp_ready != 2'b00) begin
         void'(rq[g].pop_front());
         pref = 1 - g;
         grant_log.push_back(g);
         if (crossing) begin
            n_err++;
         end else begin
            mbusy      = 1'b1;
            ar_pending = 1'b1;
            cur_who    = g;
            cur_addr   = a;
            cur_len    = l;
            beats_got  = 0;
         end
      end else if (ar_pending && m_arready) begin
         ar_pending = 1'b0;
         n_ar++;
      end else if (in_data && m_rvalid && rd_ready[cur_who]) begin
         n_beats[cur_who]++;
         if (beats_got == int'(cur_len))
            mbusy = 1'b0;
         else
            beats_got++;
      end
      @(posedge clk);
      #2;
   endtask

   task automatic run_until_idle(input int bound);
      int cnt;
      cnt = 0;
      while ((rq[0].size() > 0 || rq[1].size() > 0 || mbusy) && cnt < bound) begin
         step();
         cnt++;
      end
      check_val("drain_timeout", (cnt >= bound), 1'b0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(posedge clk);
      #2;
      reset = 1'b0;
      model_clear();
   endtask

   function automatic req_t rand_req();
      req_t r;
      r.addr = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(3) == 0)
         r.addr[11:0] = 12'(4096 - 4 * $urandom_range(1, 40));
      r.len = ($urandom_range(9) < 7) ? 8'($urandom_range(7)) : 8'($urandom_range(40));
      return r;
   endfunction

   initial begin
      int gl, base_ar, base_err, base_b0, base_b1, cnt;
      p_arready = 100; p_rvalid = 100; p_rdready = 100; rlast_rand = 1'b0;
      n_err = 0; n_ar = 0; n_beats[0] = 0; n_beats[1] = 0;
      model_clear();

      // reset values with every input active
      reset     = 1'b1;
      req_valid = 2'b11;
      req_addr  = {32'h0000_3000, 32'h0000_2000};
      req_len   = {8'd1, 8'd1};
      rd_ready  = 2'b11;
      m_arready = 1'b1;
      m_rvalid  = 1'b1;
      m_rlast   = 1'b1;
      m_rdata   = 32'hDEAD_BEEF;
      repeat (2) @(posedge clk);
      #2;
      check_val("rst_req_ready", req_ready, 2'b00);
      check_val("rst_rd_valid", rd_valid, 2'b00);
      check_val("rst_rd_last", rd_last, 1'b0);
      check_val("rst_m_arvalid", m_arvalid, 1'b0);
      check_val("rst_m_rready", m_rready, 1'b0);
      check_val("rst_busy", busy, 1'b0);
      check_val("rst_err_4k", err_4k, 1'b0);
      check_val("rst_m_araddr", m_araddr, 32'h0);
      check_val("rst_m_arlen", m_arlen, 8'h0);
      reset = 1'b0;

      // simultaneous requests from reset: 0, 1, then 0 again
      gl = grant_log.size();
      rq[0].push_back('{addr: 32'h2000, len: 8'd0});
      rq[1].push_back('{addr: 32'h3000, len: 8'd0});
      run_until_idle(100);
      rq[0].push_back('{addr: 32'h2100, len: 8'd0});
      rq[1].push_back('{addr: 32'h3100, len: 8'd0});
      run_until_idle(100);
      check_val("rr_len", grant_log.size() - gl, 4);
      if (grant_log.size() - gl == 4) begin
         check_val("rr_g0", grant_log[gl],     0);
         check_val("rr_g1", grant_log[gl + 1], 1);
         check_val("rr_g2", grant_log[gl + 2], 0);
         check_val("rr_g3", grant_log[gl + 3], 1);
      end

      // single 4-beat burst on requester 0
      base_ar = n_ar; base_b0 = n_beats[0];
      rq[0].push_back('{addr: 32'h1000, len: 8'd3});
      run_until_idle(100);
      check_val("single_ar", n_ar - base_ar, 1);
      check_val("single_beats", n_beats[0] - base_b0, 4);
      step();

      // AR held off for 5 cycles
      base_ar   = n_ar;
      p_arready = 0;
      rq[0].push_back('{addr: 32'h7000, len: 8'd2});
      repeat (6) step();
      check_val("ar_held", n_ar - base_ar, 0);
      check_val("ar_still_valid", m_arvalid, 1'b1);
      p_arready = 100;
      run_until_idle(100);
      check_val("ar_released", n_ar - base_ar, 1);

      // 8-beat burst on requester 1 with a choppy consumer
      base_b0 = n_beats[0]; base_b1 = n_beats[1];
      p_rdready = 50;
      rq[1].push_back('{addr: 32'h8000, len: 8'd7});
      run_until_idle(200);
      check_val("choppy_beats1", n_beats[1] - base_b1, 8);
      check_val("choppy_beats0", n_beats[0] - base_b0, 0);
      p_rdready = 100;

      // 4 KB crossing rejected; exact fit accepted
      base_ar = n_ar; base_err = n_err;
      rq[0].push_back('{addr: 32'h0FF8, len: 8'd3});
      run_until_idle(50);
      step();
      check_val("x4k_err", n_err - base_err, 1);
      check_val("x4k_no_ar", n_ar - base_ar, 0);
      rq[1].push_back('{addr: 32'h0FF0, len: 8'd3});
      run_until_idle(50);
      check_val("fit4k_err", n_err - base_err, 1);
      check_val("fit4k_ar", n_ar - base_ar, 1);

      // misplaced m_rlast: burst length still governs
      rlast_rand = 1'b1;
      base_b0 = n_beats[0];
      rq[0].push_back('{addr: 32'h9000, len: 8'd5});
      run_until_idle(100);
      check_val("rlast_beats", n_beats[0] - base_b0, 6);
      rlast_rand = 1'b0;

      // reset mid-burst
      rq[0].push_back('{addr: 32'h5000, len: 8'd3});
      cnt = 0;
      while (!(mbusy && !ar_pending && beats_got == 2) && cnt < 50) begin
         step();
         cnt++;
      end
      check_val("reach_beat2", (cnt < 50), 1'b1);
      m_rvalid = 1'b1;
      rd_ready = 2'b11;
      reset    = 1'b1;
      #1;
      check_val("midrst_m_rready", m_rready, 1'b0);
      check_val("midrst_rd_valid", rd_valid, 2'b00);
      check_val("midrst_busy", busy, 1'b0);
      @(posedge clk);
      #2;
      reset = 1'b0;
      model_clear();
      repeat (3) step();
      base_ar = n_ar; base_b1 = n_beats[1];
      rq[1].push_back('{addr: 32'h6000, len: 8'd1});
      run_until_idle(50);
      check_val("post_rst_ar", n_ar - base_ar, 1);
      check_val("post_rst_beats", n_beats[1] - base_b1, 2);

      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         if (c % 200 == 0) begin
            p_arready  = $urandom_range(30, 100);
            p_rvalid   = $urandom_range(30, 100);
            p_rdready  = $urandom_range(30, 100);
            rlast_rand = ($urandom_range(3) == 0);
         end
         for (int n = 0; n < 2; n++)
            if (rq[n].size() < 3 && $urandom_range(9) == 0)
               rq[n].push_back(rand_req());
         step();
      end
      p_arready = 100; p_rvalid = 100; p_rdready = 100;
      run_until_idle(5000);
      check_val("final_idle_busy", busy, 1'b0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
